weight_load_ctrl: RTL and testbench
===================================

# weight_load_ctrl

Sequencer that streams weights from the weight RAM into the four neuron units through the RAM-to-unit weight mux. On a start pulse it walks a contiguous RAM region: NUM_UNITS blocks of WEIGHTS_PER_UNIT words, unit 0 first. For each word it drives the RAM read address, then the matching `unit_sel`/`write` pair to the mux, aligned with the one-cycle RAM read latency. It sits between the top-level training/inference control and the weight RAM/mux pair, and reports busy/done back to the top level.

## Interface
- NUM_UNITS, 4, number of neuron units; must equal 4 to match the 2-bit `unit_sel`.
- WEIGHTS_PER_UNIT, 16, words loaded per unit; 1..2^ADDR_W.
- ADDR_W, 8, weight RAM address width.
- IDX_W, 4, width of `w_index`; must satisfy 2^IDX_W >= WEIGHTS_PER_UNIT.

Ports:
- CLOCK  in  1  single clock; all state updates on its rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- start  in  1  load request; sampled only in IDLE.
- base_addr  in  ADDR_W  first RAM address of the region; captured when start is accepted.
- hold  in  1  stall; while high, no new address is issued.
- ram_addr  out  ADDR_W  weight RAM read address.
- ram_en  out  1  RAM read enable; high only in cycles that issue an address.
- unit_sel  out  2  mux unit select, aligned with RAM data.
- write  out  1  mux write strobe, aligned with RAM data.
- w_index  out  IDX_W  weight slot index within the unit, aligned with `write`.
- busy  out  1  high from the cycle after start is accepted through the DRAIN state.
- done  out  1  one-cycle pulse after the final write.

## Operation
- States:
  - IDLE: wait for start.
  - FETCH: issue addresses.
  - DRAIN: final write in flight.
  - DONE: pulse `done`.
- Transitions:
  - IDLE→FETCH when start=1. Capture base_addr; clear the unit counter u and index counter i.
  - FETCH stays in FETCH while there are words left to issue.
  - FETCH→DRAIN in the cycle after the last issue (u=NUM_UNITS-1, i=WEIGHTS_PER_UNIT-1) completes.
  - DRAIN→DONE after one cycle.
  - DONE→IDLE after one cycle.
- Issue cycle: a FETCH cycle with hold=0. In an issue cycle:
  - ram_en=1 and ram_addr = base + u*WEIGHTS_PER_UNIT + i, taken modulo 2^ADDR_W; the address wraps past the top of RAM.
  - i increments. When i reaches WEIGHTS_PER_UNIT-1, the next issue sets i=0 and u+1.
- Data stage: one registered pipeline stage. In the cycle after an issue cycle:
  - write=1, unit_sel=u of that issue, w_index=i of that issue.
  - After a non-issue cycle (stall or not in FETCH), write=0.
- unit_sel and w_index hold their last value when write=0.
- hold=1 in FETCH:
  - ram_en=0 and the counters freeze.
  - A write already in the data stage still completes.
- start while not in IDLE is ignored. base_addr is ignored outside the accepting cycle.
- Reset (RESET_N=0 at a rising edge), including mid-load:
  - state=IDLE, counters=0, captured base=0.
  - All outputs 0: ram_addr, ram_en, unit_sel, write, w_index, busy, done.
  - An in-flight write is dropped. No done is produced for an aborted load.

## Timing
- Edge E0: start=1 sampled in IDLE.
- Cycle after E0: busy=1, ram_en=1, ram_addr=base.
- One cycle later: write=1, unit_sel=0, w_index=0. The mux registers this, so the unit sees weight0 two cycles after the address was issued.
- With no stalls:
  - 64 issue cycles for the defaults.
  - Last write in the DRAIN cycle, which is cycle 65 after E0.
  - done=1 and busy=0 in cycle 66.
  - Back in IDLE in cycle 67, where start can be accepted again.
- Each stalled FETCH cycle delays every later event by exactly one cycle.
- write is never high in two consecutive cycles with different unit_sel unless both came from issue cycles. Writes are strictly in ascending (u, i) order, each (u, i) exactly once per load.

## Test plan
- Basic load, base_addr=0x00, hold=0 -> ram_addr sequence 0x00..0x3F on consecutive cycles. write high for 64 consecutive cycles: unit_sel=0 for the first 16 with w_index 0..15, then 1, 2, 3. done pulses exactly 2 cycles after the last ram_en.
- Wrap: base_addr=0xF0 -> addresses 0xF0..0xFF then 0x00..0x2F. unit 1 starts at address 0x00.
- Stall: hold high for 3 cycles while issuing u=1, i=5 -> ram_en low for 3 cycles and ram_addr frozen. The write for i=4 still occurs, followed by 3 write=0 cycles. done is delayed by 3 cycles. All 64 writes are present, with no duplicates.
- Start while busy: pulse start with base_addr=0x80 mid-load -> ignored; addresses continue from the original base.
- Reset mid-load: RESET_N=0 for one edge at u=2, i=7 -> next cycle all outputs 0, state IDLE, no done. A new start with base 0x10 produces a full clean load from 0x10.
- Back-to-back: start held high continuously -> new load accepted in the first IDLE cycle after the DONE pulse. busy low for exactly 2 cycles (DONE, IDLE) between the two loads.

Source files
------------

// File: rtl/weight_load_ctrl.sv
// Weight load sequencer: walks a contiguous weight RAM region and drives the
// RAM-to-unit mux with unit_sel/write/w_index aligned to the one-cycle RAM read latency.
module weight_load_ctrl #(
  parameter int NUM_UNITS        = 4,
  parameter int WEIGHTS_PER_UNIT = 16,
  parameter int ADDR_W           = 8,
  parameter int IDX_W            = 4
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              hold,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_en,
  output logic [1:0]        unit_sel,
  output logic              write,
  output logic [IDX_W-1:0]  w_index,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  localparam logic [1:0]       U_LAST = 2'(NUM_UNITS - 1);
  localparam logic [IDX_W-1:0] I_LAST = IDX_W'(WEIGHTS_PER_UNIT - 1);

  state_t            state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [1:0]        u_reg;
  logic [IDX_W-1:0]  i_reg;
  logic [1:0]        sel_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic              write_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              issue;
  logic              last_issue;

  // The region is contiguous, so the address is just base plus a running count.
  assign issue      = (state_reg == FETCH) && !hold;
  assign last_issue = issue && (u_reg == U_LAST) && (i_reg == I_LAST);

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      u_reg     <= '0;
      i_reg     <= '0;
      sel_reg   <= '0;
      idx_reg   <= '0;
      write_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      // Data stage: one cycle behind the issued address, matching RAM latency.
      write_reg <= issue;
      if (issue) begin
        sel_reg  <= u_reg;
        idx_reg  <= i_reg;
        addr_reg <= addr_reg + 1'b1;
        if (i_reg == I_LAST) begin
          i_reg <= '0;
          u_reg <= u_reg + 1'b1;
        end else begin
          i_reg <= i_reg + 1'b1;
        end
      end

      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            state_reg <= FETCH;
            addr_reg  <= base_addr;
            u_reg     <= '0;
            i_reg     <= '0;
            busy_reg  <= 1'b1;
          end
        end
        FETCH: begin
          if (last_issue) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          state_reg <= DONE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
        end
        DONE: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign ram_addr = addr_reg;
  assign ram_en   = issue;
  assign unit_sel = sel_reg;
  assign write    = write_reg;
  assign w_index  = idx_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Bench for weight_load_ctrl: linear-index reference model checked every cycle,
// plus per-scenario hand-derived timeline expectations.
module tb_weight_load_ctrl;

  localparam int WPU   = 16;
  localparam int NU    = 4;
  localparam int TOTAL = WPU * NU;

  localparam int P_IDLE  = 0;
  localparam int P_FETCH = 1;
  localparam int P_DRAIN = 2;
  localparam int P_DONE  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       hold = 1'b0;
  logic [7:0] base_addr = 8'h00;
  logic [7:0] ram_addr;
  logic       ram_en;
  logic [1:0] unit_sel;
  logic       write;
  logic [3:0] w_index;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  weight_load_ctrl #(
    .NUM_UNITS(NU), .WEIGHTS_PER_UNIT(WPU), .ADDR_W(8), .IDX_W(4)
  ) dut (
    .CLOCK(clk), .RESET_N(rst_n), .start(start), .base_addr(base_addr), .hold(hold),
    .ram_addr(ram_addr), .ram_en(ram_en), .unit_sel(unit_sel), .write(write),
    .w_index(w_index), .busy(busy), .done(done)
  );

  int n_checks = 0;
  int n_errors = 0;
  int scen = 99;

  // Reference model: load progress as a linear word count n; unit/slot by div/mod.
  int m_phase = P_IDLE;
  int m_base  = 0;
  int m_n     = 0;
  int m_us    = 0;
  int m_wi    = 0;
  int m_wr    = 0;
  int m_k     = 100000;
  bit chk_en  = 1'b0;
  int wcnt    = 0;

  always @(posedge clk) begin
    bit acc;
    bit iss;
    if (m_k < 100000) m_k = m_k + 1;
    if (!rst_n) begin
      m_phase = P_IDLE;
      m_base  = 0;
      m_n     = 0;
      m_us    = 0;
      m_wi    = 0;
      m_wr    = 0;
      chk_en  = 1'b1;
    end else begin
      acc  = (m_phase == P_IDLE) && start;
      iss  = (m_phase == P_FETCH) && !hold;
      m_wr = int'(iss);
      if (iss) begin
        m_us = m_n / WPU;
        m_wi = m_n % WPU;
        m_n  = m_n + 1;
      end
      if (acc) begin
        m_phase = P_FETCH;
        m_base  = int'(base_addr);
        m_n     = 0;
        m_k     = 1;
      end else if (m_phase == P_FETCH) begin
        if (m_n == TOTAL) m_phase = P_DRAIN;
      end else if (m_phase == P_DRAIN) begin
        m_phase = P_DONE;
      end else if (m_phase == P_DONE) begin
        m_phase = P_IDLE;
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    n_checks = n_checks + 1;
    if (act != req) begin
      n_errors = n_errors + 1;
      $display("FAIL %s actual=%0d required=%0d (scen %0d, k %0d, t=%0t)",
               name, act, req, scen, m_k, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ram_en", int'(ram_en), int'((m_phase == P_FETCH) && !hold));
      chk("ram_addr", int'(ram_addr), (m_base + m_n) % 256);
      chk("write", int'(write), m_wr);
      chk("unit_sel", int'(unit_sel), m_us);
      chk("w_index", int'(w_index), m_wi);
      chk("busy", int'(busy), int'((m_phase == P_FETCH) || (m_phase == P_DRAIN)));
      chk("done", int'(done), int'(m_phase == P_DONE));
      if (m_phase == P_IDLE) wcnt = 0;
      else if (write === 1'b1) wcnt = wcnt + 1;
      if (m_phase == P_DONE) chk("write_count", wcnt, TOTAL);

      case (scen)
        99: begin
          chk("rst_addr", int'(ram_addr), 0);
          chk("rst_en", int'(ram_en), 0);
          chk("rst_write", int'(write), 0);
          chk("rst_busy", int'(busy), 0);
          chk("rst_done", int'(done), 0);
        end
        1: if (m_k >= 1 && m_k <= 67) begin
          chk("basic_en", int'(ram_en), int'(m_k <= 64));
          if (m_k <= 64) chk("basic_addr", int'(ram_addr), m_k - 1);
          chk("basic_write", int'(write), int'(m_k >= 2 && m_k <= 65));
          if (m_k >= 2 && m_k <= 65) begin
            chk("basic_unit", int'(unit_sel), (m_k - 2) / 16);
            chk("basic_idx", int'(w_index), (m_k - 2) % 16);
          end
          chk("basic_done", int'(done), int'(m_k == 66));
          chk("basic_busy", int'(busy), int'(m_k <= 65));
        end
        2: begin
          if (m_k == 1)  chk("wrap_first", int'(ram_addr), 'hF0);
          if (m_k == 16) chk("wrap_top", int'(ram_addr), 'hFF);
          if (m_k == 17) chk("wrap_zero", int'(ram_addr), 'h00);
          if (m_k == 18) begin
            chk("wrap_u1_write", int'(write), 1);
            chk("wrap_u1_unit", int'(unit_sel), 1);
            chk("wrap_u1_idx", int'(w_index), 0);
          end
          if (m_k == 64) chk("wrap_last", int'(ram_addr), 'h2F);
        end
        3: begin
          if (m_k >= 22 && m_k <= 24) begin
            chk("stall_en", int'(ram_en), 0);
            chk("stall_addr", int'(ram_addr), 'h15);
          end
          if (m_k == 22) begin
            chk("stall_w4", int'(write), 1);
            chk("stall_w4_unit", int'(unit_sel), 1);
            chk("stall_w4_idx", int'(w_index), 4);
          end
          if (m_k >= 23 && m_k <= 25) chk("stall_gap", int'(write), 0);
          if (m_k == 25) begin
            chk("stall_resume_en", int'(ram_en), 1);
            chk("stall_resume_addr", int'(ram_addr), 'h15);
          end
          if (m_k == 26) chk("stall_w5_idx", int'(w_index), 5);
          if (m_k == 68) chk("stall_done_early", int'(done), 0);
          if (m_k == 69) chk("stall_done", int'(done), 1);
        end
        4: begin
          if (m_k == 11) chk("busy_start_addr", int'(ram_addr), 'h2A);
          if (m_k == 64) chk("busy_start_last", int'(ram_addr), 'h5F);
          if (m_k == 66) chk("busy_start_done", int'(done), 1);
        end
        5: begin
          if (m_k == 40) chk("rstmid_addr", int'(ram_addr), 'h67);
          if (m_k == 41) begin
            chk("rstmid_addr0", int'(ram_addr), 0);
            chk("rstmid_en0", int'(ram_en), 0);
            chk("rstmid_unit0", int'(unit_sel), 0);
            chk("rstmid_write0", int'(write), 0);
            chk("rstmid_idx0", int'(w_index), 0);
            chk("rstmid_busy0", int'(busy), 0);
          end
          if (m_k >= 41 && m_k <= 75) chk("rstmid_nodone", int'(done), 0);
        end
        6: begin
          if (m_k == 1) chk("reload_addr", int'(ram_addr), 'h10);
          if (m_k == 65) begin
            chk("reload_last_unit", int'(unit_sel), 3);
            chk("reload_last_idx", int'(w_index), 15);
          end
          if (m_k == 66) chk("reload_done", int'(done), 1);
        end
        7: begin
          if (m_k == 1) begin
            chk("b2b_busy_start", int'(busy), 1);
            chk("b2b_addr_start", int'(ram_addr), 'h30);
          end
          if (m_k == 65) chk("b2b_busy_drain", int'(busy), 1);
          if (m_k == 66) begin
            chk("b2b_busy_done", int'(busy), 0);
            chk("b2b_done", int'(done), 1);
          end
          if (m_k == 67) begin
            chk("b2b_busy_idle", int'(busy), 0);
            chk("b2b_en_idle", int'(ram_en), 0);
          end
        end
        default: ;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_start(input logic [7:0] b);
    start     = 1'b1;
    base_addr = b;
    step();
    start     = 1'b0;
    base_addr = 8'($urandom);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();

    scen = 1;
    go_start(8'h00);
    repeat (75) step();

    scen = 2;
    go_start(8'hF0);
    repeat (75) step();

    scen = 3;
    go_start(8'h00);
    for (int k = 1; k <= 75; k++) begin
      hold = (k >= 22 && k <= 24);
      step();
    end
    hold = 1'b0;

    scen = 4;
    go_start(8'h20);
    for (int k = 1; k <= 75; k++) begin
      start     = (k == 10);
      base_addr = (k == 10) ? 8'h80 : 8'($urandom);
      step();
    end
    start = 1'b0;

    scen = 5;
    go_start(8'h40);
    for (int k = 1; k <= 75; k++) begin
      rst_n = (k != 40);
      step();
    end
    rst_n = 1'b1;

    scen = 6;
    go_start(8'h10);
    repeat (75) step();

    scen = 7;
    start     = 1'b1;
    base_addr = 8'h30;
    repeat (68) step();
    start = 1'b0;
    repeat (75) step();

    scen = 0;
    for (int c = 0; c < 2500; c++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      start     = ($urandom_range(0, 9) == 0);
      hold      = ($urandom_range(0, 3) == 0);
      base_addr = 8'($urandom);
      step();
    end
    rst_n = 1'b1;
    start = 1'b0;
    hold  = 1'b0;
    repeat (200) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
